// File: rtl/mul_ctrl_pkg.sv
// Shared opcodes, FSM state encoding and default iteration count for the
// multiplier scheduler.
package mul_ctrl_pkg;

  localparam int         ITER_DEFAULT = 32;
  localparam logic [5:0] OP_MULTU     = 6'b011001;
  localparam logic [5:0] OP_OUT       = 6'b111111;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_RUN   = 3'd2,
    ST_DRAIN = 3'd3,
    ST_DONE  = 3'd4
  } mul_state_e;

  // Index of the highest set bit plus one; zero operand maps to 1 RUN cycle.
  function automatic int run_len(input logic [31:0] b);
    int n;
    n = 1;
    for (int i = 0; i < 32; i++) begin
      if (b[i]) n = i + 1;
    end
    return n;
  endfunction

endpackage

// File: rtl/mul_rr_arbiter.sv
// Two-way round-robin grant: on a tie the requester that did not own the
// previous operation wins; a lone request is always granted.
module mul_rr_arbiter (
  input  logic req0,
  input  logic req1,
  input  logic last_owner,
  output logic grant
);

  always_comb begin
    grant = 1'b0;
    if (req0 && req1) begin
      grant = ~last_owner;
    end else if (req1) begin
      grant = 1'b1;
    end
  end

endmodule

// File: rtl/mul_sched.sv
// Scheduler sharing one shift-add multiplier between two requesters.
// Optional build macro MUL_EARLY_EXIT_EN shortens RUN to the multiplier width.
//
// state    | meaning
// IDLE     | waiting for a request, arbitration and operand latch
// LOAD     | mul_load pulse, operands presented to the multiplier
// RUN      | MULTU iterations
// DRAIN    | multiplier settles, product captured on exit
// DONE     | done pulse to the owner, last_owner updated on exit
module mul_sched
  import mul_ctrl_pkg::*;
#(
  parameter int ITER = ITER_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req0,
  input  logic        req1,
  input  logic [31:0] a0,
  input  logic [31:0] a1,
  input  logic [31:0] b0,
  input  logic [31:0] b1,
  output logic        done0,
  output logic        done1,
  output logic [63:0] result,
  output logic        busy,
  output logic [5:0]  mul_signal,
  output logic        mul_load,
  output logic [31:0] mul_a,
  output logic [31:0] mul_b,
  input  logic [63:0] mul_product
);

  localparam logic [5:0] ITER_LAST = 6'(ITER - 1);

  mul_state_e  state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic        owner_q, owner_d;
  logic        last_owner_q, last_owner_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [63:0] result_q, result_d;
  logic        grant;
  logic        run_last;

`ifdef MUL_EARLY_EXIT_EN
  logic [31:0] shadow_q, shadow_d;
`endif

  mul_rr_arbiter u_arb (
    .req0       (req0),
    .req1       (req1),
    .last_owner (last_owner_q),
    .grant      (grant)
  );

`ifdef MUL_EARLY_EXIT_EN
  // Leave once no multiplier bits remain beyond the one consumed this cycle.
  assign run_last = (cnt_q == ITER_LAST) || (shadow_q[31:1] == 31'd0);
`else
  assign run_last = (cnt_q == ITER_LAST);
`endif

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    owner_d      = owner_q;
    last_owner_d = last_owner_q;
    a_d          = a_q;
    b_d          = b_q;
    result_d     = result_q;
`ifdef MUL_EARLY_EXIT_EN
    shadow_d     = shadow_q;
`endif
    case (state_q)
      ST_IDLE: begin
        if (req0 || req1) begin
          owner_d = grant;
          a_d     = grant ? a1 : a0;
          b_d     = grant ? b1 : b0;
          state_d = ST_LOAD;
        end
      end
      ST_LOAD: begin
        cnt_d   = 6'd0;
`ifdef MUL_EARLY_EXIT_EN
        shadow_d = b_q;
`endif
        state_d = ST_RUN;
      end
      ST_RUN: begin
        cnt_d = cnt_q + 6'd1;
`ifdef MUL_EARLY_EXIT_EN
        shadow_d = shadow_q >> 1;
`endif
        if (run_last) state_d = ST_DRAIN;
      end
      ST_DRAIN: begin
        result_d = mul_product;
        state_d  = ST_DONE;
      end
      ST_DONE: begin
        last_owner_d = owner_q;
        state_d      = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      cnt_q        <= 6'd0;
      owner_q      <= 1'b0;
      last_owner_q <= 1'b1;
      a_q          <= 32'd0;
      b_q          <= 32'd0;
      result_q     <= 64'd0;
`ifdef MUL_EARLY_EXIT_EN
      shadow_q     <= 32'd0;
`endif
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      owner_q      <= owner_d;
      last_owner_q <= last_owner_d;
      a_q          <= a_d;
      b_q          <= b_d;
      result_q     <= result_d;
`ifdef MUL_EARLY_EXIT_EN
      shadow_q     <= shadow_d;
`endif
    end
  end

  assign busy       = (state_q != ST_IDLE);
  assign mul_load   = (state_q == ST_LOAD);
  assign mul_signal = (state_q == ST_RUN) ? OP_MULTU : OP_OUT;
  assign done0      = (state_q == ST_DONE) && !owner_q;
  assign done1      = (state_q == ST_DONE) && owner_q;
  assign mul_a      = a_q;
  assign mul_b      = b_q;
  assign result     = result_q;

endmodule

// File: tb/tb_mul_sched.sv
// Directed and randomized bench for mul_sched with a behavioural shift-add
// multiplier and a queue-free arbitration/latency reference model.
module tb_mul_sched;

  localparam int         ITER  = 32;
  localparam logic [5:0] MULTU = 6'b011001;
  localparam logic [5:0] OUTOP = 6'b111111;

  logic        clk = 1'b0;
  logic        reset;
  logic        req0, req1;
  logic [31:0] a0, a1, b0, b1;
  logic        done0, done1, busy, mul_load;
  logic [63:0] result, mul_product;
  logic [5:0]  mul_signal;
  logic [31:0] mul_a, mul_b;

  int n_assert = 0;
  int n_fail   = 0;
  logic model_last = 1'b1;

  mul_sched #(.ITER(ITER)) dut (
    .clk(clk), .reset(reset), .req0(req0), .req1(req1),
    .a0(a0), .a1(a1), .b0(b0), .b1(b1),
    .done0(done0), .done1(done1), .result(result), .busy(busy),
    .mul_signal(mul_signal), .mul_load(mul_load),
    .mul_a(mul_a), .mul_b(mul_b), .mul_product(mul_product)
  );

  always #5 clk = ~clk;

  // External shift-add multiplier: one multiplier bit per MULTU cycle, LSB first.
  logic [63:0] mp_acc = 64'd0;
  logic [31:0] mp_a = 32'd0, mp_b = 32'd0;
  int          mp_idx = 0;
  always @(posedge clk) begin
    if (mul_load) begin
      mp_acc <= 64'd0;
      mp_a   <= mul_a;
      mp_b   <= mul_b;
      mp_idx <= 0;
    end else if (mul_signal == MULTU) begin
      if (mp_idx < 32 && mp_b[mp_idx]) mp_acc <= mp_acc + ({32'd0, mp_a} << mp_idx);
      mp_idx <= mp_idx + 1;
    end
  end
  assign mul_product = mp_acc;

  function automatic logic [63:0] prod(input logic [31:0] x, input logic [31:0] y);
    logic [63:0] xx, yy;
    xx = {32'd0, x};
    yy = {32'd0, y};
    return xx * yy;
  endfunction

  // Edges from the acceptance edge to the edge after which done is visible.
  function automatic int lat_of(input logic [31:0] b);
`ifdef MUL_EARLY_EXIT_EN
    int m;
    m = 1;
    for (int i = 0; i < 32; i++) if (b[i]) m = i + 1;
    if (m > ITER) m = ITER;
    return m + 2;
`else
    return ITER + 2;
`endif
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp)
    else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_done(input int max_cyc, output int cyc, output logic d0, output logic d1);
    cyc = 0;
    d0  = 1'b0;
    d1  = 1'b0;
    while (cyc < max_cyc && !(d0 || d1)) begin
      @(posedge clk);
      #1;
      cyc++;
      d0 = done0;
      d1 = done1;
    end
  endtask

  // Waits for the owner's done and checks pulse, product and edge count.
  task automatic serve(input string tag, input logic own, input logic [63:0] exp_res, input int exp_cyc);
    int   cyc;
    logic d0, d1;
    wait_done(exp_cyc + 60, cyc, d0, d1);
    check({tag, "_done0"}, {63'd0, d0}, {63'd0, !own});
    check({tag, "_done1"}, {63'd0, d1}, {63'd0, own});
    check({tag, "_result"}, result, exp_res);
    check({tag, "_cycles"}, 64'(cyc), 64'(exp_cyc));
    if (own) req1 = 1'b0; else req0 = 1'b0;
    model_last = own;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b1;
    req0  = 1'b0;
    req1  = 1'b0;
    @(posedge clk);
    #1;
    reset = 1'b0;
    model_last = 1'b1;
  endtask

  initial begin
    logic [1:0] pat;
    logic       p0, p1, own, first;

    reset = 1'b1; req0 = 1'b0; req1 = 1'b0;
    a0 = '0; a1 = '0; b0 = '0; b1 = '0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_busy", {63'd0, busy}, 64'd0);
    check("rst_done0", {63'd0, done0}, 64'd0);
    check("rst_done1", {63'd0, done1}, 64'd0);
    check("rst_load", {63'd0, mul_load}, 64'd0);
    check("rst_sig", {58'd0, mul_signal}, {58'd0, OUTOP});
    check("rst_a", {32'd0, mul_a}, 64'd0);
    check("rst_b", {32'd0, mul_b}, 64'd0);
    check("rst_result", result, 64'd0);
    reset = 1'b0;

    // Lone req0; operand changes and a req1 blip during the op are ignored.
    a0 = 32'd3; b0 = 32'd5; req0 = 1'b1;
    @(posedge clk);
    #1;
    check("A_load", {63'd0, mul_load}, 64'd1);
    check("A_sig_load", {58'd0, mul_signal}, {58'd0, OUTOP});
    check("A_mul_a", {32'd0, mul_a}, 64'd3);
    check("A_mul_b", {32'd0, mul_b}, 64'd5);
    a0 = 32'd99; b0 = 32'd77; req1 = 1'b1;
    @(posedge clk);
    #1;
    check("A_sig_run", {58'd0, mul_signal}, {58'd0, MULTU});
    req1 = 1'b0;
    serve("A", 1'b0, 64'd15, lat_of(32'd5) - 1);
    @(posedge clk);
    #1;
    check("A_pulse_end", {63'd0, done0}, 64'd0);
    repeat (3) @(posedge clk);
    #1;
    check("A_idle_after", {63'd0, busy}, 64'd0);
    check("A_hold_result", result, 64'd15);

    // Simultaneous requests from reset: req0 wins, req1 follows.
    do_reset();
    a0 = 32'd2; b0 = 32'd2; a1 = 32'd7; b1 = 32'd6;
    req0 = 1'b1; req1 = 1'b1;
    serve("B0", 1'b0, 64'd4, lat_of(32'd2) + 1);
    // DONE->IDLE edge plus the acceptance edge precede the second latency.
    serve("B1", 1'b1, 64'd42, lat_of(32'd6) + 2);

    @(posedge clk);
    #1;
    a1 = 32'hFFFF_FFFF; b1 = 32'hFFFF_FFFF; req1 = 1'b1;
    serve("C", 1'b1, 64'hFFFF_FFFE_0000_0001, lat_of(32'hFFFF_FFFF) + 1);

    // Reset during RUN cycle 10 aborts silently; the requester re-requests.
    @(posedge clk);
    #1;
    a0 = 32'd123; b0 = 32'h8000_01C8; req0 = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    check("D_in_run", {58'd0, mul_signal}, {58'd0, MULTU});
    reset = 1'b1;
    @(posedge clk);
    #1;
    reset = 1'b0;
    req0 = 1'b0;
    model_last = 1'b1;
    check("D_busy", {63'd0, busy}, 64'd0);
    check("D_done0", {63'd0, done0}, 64'd0);
    check("D_result", result, 64'd0);
    check("D_sig", {58'd0, mul_signal}, {58'd0, OUTOP});
    check("D_mul_a", {32'd0, mul_a}, 64'd0);
    repeat (40) @(posedge clk);
    #1;
    check("D_no_done", {62'd0, done0, done1}, 64'd0);
    check("D_still_idle", {63'd0, busy}, 64'd0);
    req0 = 1'b1;
    serve("D_retry", 1'b0, prod(32'd123, 32'h8000_01C8), lat_of(32'h8000_01C8) + 1);

`ifdef MUL_EARLY_EXIT_EN
    @(posedge clk);
    #1;
    a0 = 32'd9; b0 = 32'd1; req0 = 1'b1;
    serve("E_b1", 1'b0, 64'd9, 4);
    @(posedge clk);
    #1;
    a0 = 32'd9; b0 = 32'd0; req0 = 1'b1;
    serve("E_b0", 1'b0, 64'd0, 4);
`endif

    // Random request patterns against the round-robin/latency model.
    for (int r = 0; r < 10; r++) begin
      @(posedge clk);
      #1;
      pat = 2'($urandom_range(1, 3));
      a0 = $urandom; a1 = $urandom;
      b0 = $urandom >> $urandom_range(0, 31);
      b1 = $urandom >> $urandom_range(0, 31);
      req0 = pat[0]; req1 = pat[1];
      p0 = pat[0]; p1 = pat[1];
      first = 1'b1;
      while (p0 || p1) begin
        own = (p0 && p1) ? !model_last : p1;
        serve($sformatf("R%0d_%0d", r, own), own,
              own ? prod(a1, b1) : prod(a0, b0),
              (own ? lat_of(b1) : lat_of(b0)) + (first ? 1 : 2));
        if (own) p1 = 1'b0; else p0 = 1'b0;
        first = 1'b0;
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
